// File: rtl/udp_cmd_dispatcher.sv
// udp_cmd_dispatcher
//   Parses UDP command packets and dispatches data-move commands
//   (camera/sdcard -> SDRAM, SDRAM -> HDMI). Holds one active command plus a
//   one-deep pending command, and stays busy until the finish strobe that
//   matches the active command's direction arrives.
//
// Ports
//   udp_rx_clk            in   sole clock
//   reset                 in   synchronous active-low reset
//   app_rx_data_valid     in   payload byte strobe
//   app_rx_data[7:0]      in   payload byte, first byte is byte 0
//   app_rx_data_length    in   payload length in bytes, stable per packet
//   read_finish           in   read-path done (asynchronous)
//   write_finish          in   write-path done (asynchronous)
//   cmd_valid             out  1-cycle pulse: a command became active
//   cmd_drop              out  1-cycle pulse: packet rejected or queue overflow
//   busy                  out  a command is active
//   read_ch               out  read port select
//   write_ch              out  write port select
//   sdram_index           out  SDRAM buffer index
//   sd_card_bmp_read_addr out  SD read address of the active command
module udp_cmd_dispatcher #(
  parameter logic [7:0]  MAGIC      = 8'hA5,
  parameter int          CMD_OFFSET = 2,
  parameter logic [31:0] SD_BASE    = 32'd8484,
  parameter logic [31:0] SD_STRIDE  = 32'd1800,
  parameter int          CH_W       = 2
) (
  input  logic            udp_rx_clk,
  input  logic            reset,
  input  logic            app_rx_data_valid,
  input  logic [7:0]      app_rx_data,
  input  logic [15:0]     app_rx_data_length,
  input  logic            read_finish,
  input  logic            write_finish,
  output logic            cmd_valid,
  output logic            cmd_drop,
  output logic            busy,
  output logic [CH_W-1:0] read_ch,
  output logic [CH_W-1:0] write_ch,
  output logic [CH_W-1:0] sdram_index,
  output logic [31:0]     sd_card_bmp_read_addr
);

  // Only the two low command bytes carry fields; the upper two are reserved.
  localparam logic [15:0] CMD_HI_IDX = 16'(CMD_OFFSET + 2);
  localparam logic [15:0] CMD_LO_IDX = 16'(CMD_OFFSET + 3);
  localparam logic [15:0] MIN_LEN    = 16'(CMD_OFFSET + 4);

  typedef enum logic [0:0] {IDLE, ACTIVE} state_t;

  function automatic logic [31:0] calc_addr(input logic [9:0] idx);
    logic [31:0] idx32;
    idx32 = {22'd0, idx};
    // idx==0 deliberately wraps modulo 2^32
    return (idx32 - 32'd1) * SD_STRIDE + SD_BASE;
  endfunction

  function automatic logic [CH_W-1:0] wr_ch_of(input logic [1:0] t);
    case (t)
      2'd1:    return CH_W'(1);
      2'd2:    return CH_W'(2);
      default: return CH_W'(0);
    endcase
  endfunction

  function automatic logic [CH_W-1:0] rd_ch_of(input logic [1:0] t);
    return (t == 2'd3) ? CH_W'(1) : CH_W'(0);
  endfunction

  logic [15:0] byte_cnt;
  logic        magic_ok;
  logic [7:0]  cmd_hi;
  logic [7:0]  cmd_lo;

  logic        last_byte;
  logic [15:0] word_now;
  logic [3:0]  type_now;
  logic        pkt_ok;
  logic        commit_ok;
  logic        commit_bad;

  // ---- stage p0..p2: finish synchronisers and rising-edge detect ----
  logic rd_fin_p0, rd_fin_p1, rd_fin_p2;
  logic wr_fin_p0, wr_fin_p1, wr_fin_p2;
  logic rd_done, wr_done;

  always_ff @(posedge udp_rx_clk) begin
    if (!reset) begin
      rd_fin_p0 <= 1'b0;
      rd_fin_p1 <= 1'b0;
      rd_fin_p2 <= 1'b0;
      wr_fin_p0 <= 1'b0;
      wr_fin_p1 <= 1'b0;
      wr_fin_p2 <= 1'b0;
    end else begin
      rd_fin_p0 <= read_finish;
      rd_fin_p1 <= rd_fin_p0;
      rd_fin_p2 <= rd_fin_p1;
      wr_fin_p0 <= write_finish;
      wr_fin_p1 <= wr_fin_p0;
      wr_fin_p2 <= wr_fin_p1;
    end
  end

  assign rd_done = rd_fin_p1 & ~rd_fin_p2;
  assign wr_done = wr_fin_p1 & ~wr_fin_p2;

  // ---- byte counter and field capture ----
  assign last_byte = app_rx_data_valid && (app_rx_data_length != 16'd0) &&
                     (byte_cnt == app_rx_data_length - 16'd1);

  always_ff @(posedge udp_rx_clk) begin
    if (!reset) begin
      byte_cnt <= 16'd0;
      magic_ok <= 1'b0;
      cmd_hi   <= 8'd0;
      cmd_lo   <= 8'd0;
    end else if (app_rx_data_length == 16'd0) begin
      byte_cnt <= 16'd0;
    end else if (app_rx_data_valid) begin
      byte_cnt <= last_byte ? 16'd0 : byte_cnt + 16'd1;
      if (byte_cnt == 16'd0)        magic_ok <= (app_rx_data == MAGIC);
      if (byte_cnt == CMD_HI_IDX)   cmd_hi   <= app_rx_data;
      if (byte_cnt == CMD_LO_IDX)   cmd_lo   <= app_rx_data;
    end
  end

  // The final command byte may arrive on the commit cycle itself.
  always_comb begin
    word_now = {cmd_hi, cmd_lo};
    if (byte_cnt == CMD_LO_IDX) word_now = {cmd_hi, app_rx_data};
  end

  assign type_now   = word_now[3:0];
  assign pkt_ok     = magic_ok && (app_rx_data_length >= MIN_LEN) &&
                      ((type_now == 4'd1) || (type_now == 4'd2) || (type_now == 4'd3));
  assign commit_ok  = last_byte && pkt_ok;
  assign commit_bad = last_byte && !pkt_ok;

  // ---- command FSM ----
  state_t      state;
  logic [1:0]  act_type;
  logic        pend_vld;
  logic [1:0]  pend_type;
  logic [1:0]  pend_sdram;
  logic [31:0] pend_addr;

  logic        done_m;
  logic        take_pend;
  logic [1:0]  ld_type;
  logic [1:0]  ld_sdram;
  logic [31:0] ld_addr;
  logic [31:0] new_addr;

  assign done_m    = (act_type == 2'd3) ? rd_done : wr_done;
  assign new_addr  = calc_addr(word_now[15:6]);
  assign take_pend = (state == ACTIVE) && done_m && pend_vld;

  always_comb begin
    ld_type  = word_now[1:0];
    ld_sdram = word_now[5:4];
    ld_addr  = new_addr;
    if (take_pend) begin
      ld_type  = pend_type;
      ld_sdram = pend_sdram;
      ld_addr  = pend_addr;
    end
  end

  always_ff @(posedge udp_rx_clk) begin
    if (!reset) begin
      state                 <= IDLE;
      act_type              <= 2'd0;
      pend_vld              <= 1'b0;
      pend_type             <= 2'd0;
      pend_sdram            <= 2'd0;
      pend_addr             <= 32'd0;
      cmd_valid             <= 1'b0;
      cmd_drop              <= 1'b0;
      busy                  <= 1'b0;
      read_ch               <= '0;
      write_ch              <= '0;
      sdram_index           <= '0;
      sd_card_bmp_read_addr <= 32'd0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_drop  <= commit_bad;
      case (state)
        IDLE: begin
          if (commit_ok) begin
            state                 <= ACTIVE;
            busy                  <= 1'b1;
            cmd_valid             <= 1'b1;
            act_type              <= ld_type;
            write_ch              <= wr_ch_of(ld_type);
            read_ch               <= rd_ch_of(ld_type);
            sdram_index           <= CH_W'(ld_sdram);
            sd_card_bmp_read_addr <= ld_addr;
          end
        end
        ACTIVE: begin
          if (done_m && (pend_vld || commit_ok)) begin
            // Done is retired first, then pending (or the new command) moves up.
            cmd_valid             <= 1'b1;
            act_type              <= ld_type;
            write_ch              <= wr_ch_of(ld_type);
            read_ch               <= rd_ch_of(ld_type);
            sdram_index           <= CH_W'(ld_sdram);
            sd_card_bmp_read_addr <= ld_addr;
            if (pend_vld) begin
              pend_vld   <= commit_ok;
              pend_type  <= word_now[1:0];
              pend_sdram <= word_now[5:4];
              pend_addr  <= new_addr;
            end
          end else if (done_m) begin
            state                 <= IDLE;
            busy                  <= 1'b0;
            act_type              <= 2'd0;
            write_ch              <= '0;
            read_ch               <= '0;
            sdram_index           <= '0;
            sd_card_bmp_read_addr <= 32'd0;
          end else if (commit_ok) begin
            if (!pend_vld) begin
              pend_vld   <= 1'b1;
              pend_type  <= word_now[1:0];
              pend_sdram <= word_now[5:4];
              pend_addr  <= new_addr;
            end else begin
              cmd_drop <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_cmd_dispatcher.sv
// tb_udp_cmd_dispatcher
//   Directed bench for udp_cmd_dispatcher: drives command packets byte by
//   byte on the falling edge and checks registered outputs on the falling edge.
module tb_udp_cmd_dispatcher;

  logic        udp_rx_clk = 1'b0;
  logic        reset;
  logic        app_rx_data_valid;
  logic [7:0]  app_rx_data;
  logic [15:0] app_rx_data_length;
  logic        read_finish;
  logic        write_finish;
  logic        cmd_valid;
  logic        cmd_drop;
  logic        busy;
  logic [1:0]  read_ch;
  logic [1:0]  write_ch;
  logic [1:0]  sdram_index;
  logic [31:0] sd_card_bmp_read_addr;

  always #5 udp_rx_clk = ~udp_rx_clk;

  udp_cmd_dispatcher dut (
    .udp_rx_clk            (udp_rx_clk),
    .reset                 (reset),
    .app_rx_data_valid     (app_rx_data_valid),
    .app_rx_data           (app_rx_data),
    .app_rx_data_length    (app_rx_data_length),
    .read_finish           (read_finish),
    .write_finish          (write_finish),
    .cmd_valid             (cmd_valid),
    .cmd_drop              (cmd_drop),
    .busy                  (busy),
    .read_ch               (read_ch),
    .write_ch              (write_ch),
    .sdram_index           (sdram_index),
    .sd_card_bmp_read_addr (sd_card_bmp_read_addr)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] pkt [0:15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cmdw(input int t, input int s, input int i);
    logic [9:0] iv;
    logic [1:0] sv;
    logic [3:0] tv;
    iv = 10'(i);
    sv = 2'(s);
    tv = 4'(t);
    return {iv, sv, tv};
  endfunction

  task automatic make_pkt(input logic [7:0] m, input logic [15:0] w);
    pkt[0] = m;
    pkt[1] = 8'h00;
    pkt[2] = 8'h00;
    pkt[3] = 8'h00;
    pkt[4] = w[15:8];
    pkt[5] = w[7:0];
    for (int i = 6; i < 16; i++) pkt[i] = 8'h5C;
  endtask

  // Drives n bytes; optionally raises write_finish alongside byte fin_at.
  // Returns on the falling edge after the last byte was clocked.
  task automatic send_pkt(input int n, input int fin_at);
    app_rx_data_length = 16'(n);
    for (int i = 0; i < n; i++) begin
      @(negedge udp_rx_clk);
      if (i == fin_at) write_finish = 1'b1;
      app_rx_data_valid = 1'b1;
      app_rx_data       = pkt[i];
    end
    @(negedge udp_rx_clk);
    app_rx_data_valid = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge udp_rx_clk);
  endtask

  task automatic fin_low();
    read_finish  = 1'b0;
    write_finish = 1'b0;
    wait_neg(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b0;
    app_rx_data_valid  = 1'b0;
    app_rx_data        = 8'h00;
    app_rx_data_length = 16'd0;
    read_finish        = 1'b0;
    write_finish       = 1'b0;
    wait_neg(3);

    chk("rst_busy",  32'(busy), 0);
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_drop",  32'(cmd_drop), 0);
    chk("rst_rd",    32'(read_ch), 0);
    chk("rst_wr",    32'(write_ch), 0);
    chk("rst_idx",   32'(sdram_index), 0);
    chk("rst_addr",  sd_card_bmp_read_addr, 0);
    reset = 1'b1;
    wait_neg(2);

    // Test 1: A5 00 00 00 00 D2 00 00 -> type 2, sdram 1, idx 3
    make_pkt(8'hA5, 16'h00D2);
    pkt[6] = 8'h00;
    pkt[7] = 8'h00;
    send_pkt(8, -1);
    chk("t1_valid", 32'(cmd_valid), 1);
    chk("t1_wr",    32'(write_ch), 2);
    chk("t1_rd",    32'(read_ch), 0);
    chk("t1_idx",   32'(sdram_index), 1);
    chk("t1_addr",  sd_card_bmp_read_addr, 12084);
    chk("t1_busy",  32'(busy), 1);
    wait_neg(1);
    chk("t1_valid_pulse", 32'(cmd_valid), 0);

    // Test 2: bad magic, short length, bad type
    make_pkt(8'h5A, cmdw(3, 0, 1));
    send_pkt(8, -1);
    chk("t2_magic_drop", 32'(cmd_drop), 1);
    chk("t2_magic_wr",   32'(write_ch), 2);
    chk("t2_magic_vld",  32'(cmd_valid), 0);
    wait_neg(1);
    chk("t2_drop_pulse", 32'(cmd_drop), 0);
    make_pkt(8'hA5, cmdw(3, 0, 1));
    send_pkt(5, -1);
    chk("t2_len_drop",   32'(cmd_drop), 1);
    chk("t2_len_addr",   sd_card_bmp_read_addr, 12084);
    make_pkt(8'hA5, cmdw(7, 0, 1));
    send_pkt(8, -1);
    chk("t2_type_drop",  32'(cmd_drop), 1);
    chk("t2_type_busy",  32'(busy), 1);
    chk("t2_type_rd",    32'(read_ch), 0);
    chk("t2_type_idx",   32'(sdram_index), 1);

    // Test 3: queue a type 3, then finish the active type 2
    make_pkt(8'hA5, cmdw(3, 0, 1));
    send_pkt(8, -1);
    chk("t3_queue_vld",  32'(cmd_valid), 0);
    chk("t3_queue_drop", 32'(cmd_drop), 0);
    chk("t3_queue_wr",   32'(write_ch), 2);
    write_finish = 1'b1;
    wait_neg(2);
    chk("t3_early_wr",   32'(write_ch), 2);
    wait_neg(1);
    chk("t3_valid",      32'(cmd_valid), 1);
    chk("t3_rd",         32'(read_ch), 1);
    chk("t3_wr",         32'(write_ch), 0);
    chk("t3_addr",       sd_card_bmp_read_addr, 8484);
    chk("t3_idx",        32'(sdram_index), 0);
    fin_low();
    read_finish = 1'b1;
    wait_neg(3);
    chk("t3_idle_busy",  32'(busy), 0);
    chk("t3_idle_rd",    32'(read_ch), 0);
    chk("t3_idle_addr",  sd_card_bmp_read_addr, 0);
    fin_low();

    // Test 4: active type 1, full queue, overflow, wrong-type finish
    make_pkt(8'hA5, cmdw(1, 2, 5));
    send_pkt(8, -1);
    chk("t4_valid",      32'(cmd_valid), 1);
    chk("t4_wr",         32'(write_ch), 1);
    chk("t4_idx",        32'(sdram_index), 2);
    chk("t4_addr",       sd_card_bmp_read_addr, 15684);
    make_pkt(8'hA5, cmdw(3, 0, 2));
    send_pkt(8, -1);
    chk("t4_pend_drop",  32'(cmd_drop), 0);
    make_pkt(8'hA5, cmdw(2, 1, 7));
    send_pkt(8, -1);
    chk("t4_ovf_drop",   32'(cmd_drop), 1);
    chk("t4_ovf_addr",   sd_card_bmp_read_addr, 15684);
    read_finish = 1'b1;
    wait_neg(4);
    chk("t4_rdfin_wr",   32'(write_ch), 1);
    chk("t4_rdfin_addr", sd_card_bmp_read_addr, 15684);
    chk("t4_rdfin_busy", 32'(busy), 1);
    fin_low();
    write_finish = 1'b1;
    wait_neg(3);
    chk("t4_next_vld",   32'(cmd_valid), 1);
    chk("t4_next_rd",    32'(read_ch), 1);
    chk("t4_next_addr",  sd_card_bmp_read_addr, 10284);
    fin_low();
    read_finish = 1'b1;
    wait_neg(3);
    chk("t4_empty_busy", 32'(busy), 0);
    fin_low();

    // Test 5: matching done lands on the last byte, queue empty
    make_pkt(8'hA5, cmdw(1, 0, 1));
    send_pkt(8, -1);
    chk("t5_first_wr",   32'(write_ch), 1);
    make_pkt(8'hA5, cmdw(3, 0, 3));
    send_pkt(8, 5);
    chk("t5_valid",      32'(cmd_valid), 1);
    chk("t5_busy",       32'(busy), 1);
    chk("t5_rd",         32'(read_ch), 1);
    chk("t5_wr",         32'(write_ch), 0);
    chk("t5_addr",       sd_card_bmp_read_addr, 12084);
    fin_low();
    read_finish = 1'b1;
    wait_neg(3);
    chk("t5_idle_busy",  32'(busy), 0);
    fin_low();

    // Test 6: reset mid-packet while active, zero-length bytes, idx 0
    make_pkt(8'hA5, cmdw(1, 0, 1));
    send_pkt(8, -1);
    chk("t6_active",     32'(busy), 1);
    app_rx_data_length = 16'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge udp_rx_clk);
      app_rx_data_valid = 1'b1;
      app_rx_data       = pkt[i];
    end
    @(negedge udp_rx_clk);
    app_rx_data_valid = 1'b0;
    reset = 1'b0;
    wait_neg(2);
    chk("t6_rst_busy",   32'(busy), 0);
    chk("t6_rst_wr",     32'(write_ch), 0);
    chk("t6_rst_addr",   sd_card_bmp_read_addr, 0);
    reset = 1'b1;
    app_rx_data_length = 16'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge udp_rx_clk);
      app_rx_data_valid = 1'b1;
      app_rx_data       = 8'hA5;
    end
    @(negedge udp_rx_clk);
    app_rx_data_valid = 1'b0;
    chk("t6_len0_vld",   32'(cmd_valid), 0);
    make_pkt(8'hA5, cmdw(2, 3, 0));
    send_pkt(8, -1);
    chk("t6_valid",      32'(cmd_valid), 1);
    chk("t6_wr",         32'(write_ch), 2);
    chk("t6_idx",        32'(sdram_index), 3);
    chk("t6_addr",       sd_card_bmp_read_addr, 6684);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
